pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
//  Generic elastic pipeline register for the rv32im core; successor to the fixed per-stage flop banks.
//  Carries a packed DATA_W-bit payload between two stages with valid/ready handshake and a 2-entry skid buffer.
//  up_ready is fully registered, so back-pressure does not ripple combinationally through the pipeline.
//  Adds synchronous flush with a programmable bubble payload and a "flushed" marker, used by hazard/forwarding logic.
// PARAMETERS
//  DATA_W    256        payload width in bits (>=1)
//  RST_DATA  '0         DATA_W-bit payload driven on down_data while empty/after reset/after flush (e.g. alu_src=1)
//  CNT_W     32         perf counter width (used only with PIPE_STAGE_PERF_EN)
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous, active-high reset
//  flush          in   1        synchronous kill of all held entries
//  up_valid       in   1        upstream offers up_data
//  up_ready       out  1        stage can accept (registered)
//  up_data        in   DATA_W   upstream payload
//  down_valid     out  1        down_data is a real item
//  down_ready     in   1        downstream accepts this cycle
//  down_data      out  DATA_W   head payload; RST_DATA when !down_valid
//  down_flushed   out  1        1 after reset/flush until the first real item is accepted
//  stall_cnt      out  CNT_W    cycles with down_valid & !down_ready
//  bubble_cnt     out  CNT_W    cycles with !down_valid
//  flush_cnt      out  CNT_W    number of flush cycles
// BEHAVIOUR
//  - Transfer in: up_valid & up_ready. Transfer out: down_valid & down_ready.
//  - Storage: main reg (drives down_*) + skid reg. States EMPTY, ONE (main only), FULL (main+skid).
//  - EMPTY: in -> ONE (main<=up_data). ONE: in&!out -> FULL (skid<=up_data); !in&out -> EMPTY;
//    in&out -> ONE (main<=up_data). FULL: out -> ONE (main<=skid); in is impossible (up_ready=0).
//  - up_ready = (next state != FULL), registered; 0 only in FULL. Latency 1 cycle in->down_valid; order preserved.
//  - Pass-through throughput 1 item/cycle with down_ready held 1; no bubble on ready deassert/reassert.
//  - flush (priority over everything): next cycle state=EMPTY, down_valid=0, down_data=RST_DATA,
//    down_flushed=1, up_ready=1; any transfer in the flush cycle is discarded; down_ready ignored.
//  - down_flushed clears the cycle after the first accepted item reaches main reg.
//  - Reset (any time, incl. mid-transfer): state EMPTY, down_valid=0, down_data=RST_DATA, down_flushed=1,
//    up_ready=1, skid=RST_DATA, counters=0.
//  - up_data is sampled only on an in-transfer; X on up_data when !up_valid never propagates.
// CONFIGURATION
//  - PIPE_STAGE_PERF_EN defined: stall_cnt/bubble_cnt/flush_cnt increment per rules above, saturate at all-ones,
//    cleared only by rst; flush cycle counts in flush_cnt only.
//  - Undefined: ports still present, tied to 0; no counter flops synthesised.
// STRUCTURE
//  - pipe_pkg: typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t; localparam PIPE_CNT_W_DEF=32.
//  - Sub-module pipe_sat_counter (CNT_W, inc, rst -> saturating count), instantiated 3x under PIPE_STAGE_PERF_EN.
// TESTING
//  - Reset: rst=1 mid-FULL -> next edge down_valid=0, down_data=RST_DATA, down_flushed=1, up_ready=1.
//  - Stream: 8 items 0x1..0x8, down_ready=1 -> out 0x1..0x8 on consecutive cycles, 1-cycle latency.
//  - Back-pressure: send 0xA,0xB,0xC with down_ready=0 -> FULL after 0xB, up_ready=0, 0xC held upstream;
//    release -> 0xA,0xB,0xC in order, no loss/duplication.
//  - Flush in FULL with concurrent up_valid (0xD) -> EMPTY, 0xD dropped, down_flushed=1, flush_cnt=1.
//  - Flushed marker: after flush send 0xE -> down_flushed falls the cycle after 0xE appears on down_data.
//  - Perf (PERF_EN, CNT_W=4): hold stall 20 cycles -> stall_cnt=15 saturated; undefined -> all counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stage.
// Used by pipe_skid_stage and pipe_sat_counter.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_ONE,
    PS_FULL
  } pipe_state_t;

  localparam int PIPE_CNT_W_DEF = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, cleared only by rst.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer, registered up_ready and synchronous flush.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble/flush saturating perf counters.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 256,
  parameter logic [DATA_W-1:0] RST_DATA = '0,
  parameter int                CNT_W    = PIPE_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [DATA_W-1:0] down_data,
  output logic              down_flushed,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              up_ready_q;
  logic              flushed_q;
  logic              in_xfer, out_xfer;
  logic              load_main_up, load_main_skid, load_skid;

  assign in_xfer      = up_valid & up_ready_q;
  assign out_xfer     = down_valid & down_ready;
  assign up_ready     = up_ready_q;
  assign down_valid   = (state_q != PS_EMPTY);
  assign down_data    = down_valid ? main_q : RST_DATA;
  assign down_flushed = flushed_q;

  // State register; up_ready is precomputed from the next state so it never
  // depends combinationally on down_ready.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PS_EMPTY;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      up_ready_q <= (state_d != PS_FULL);
    end
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PS_EMPTY: if (in_xfer) state_d = PS_ONE;
      PS_ONE: begin
        if (in_xfer && !out_xfer)      state_d = PS_FULL;
        else if (!in_xfer && out_xfer) state_d = PS_EMPTY;
      end
      PS_FULL: if (out_xfer) state_d = PS_ONE;
      default: state_d = PS_EMPTY;
    endcase
    if (flush) state_d = PS_EMPTY;
  end

  always_comb begin
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      PS_EMPTY: load_main_up = in_xfer;
      PS_ONE: begin
        load_main_up = in_xfer & out_xfer;
        load_skid    = in_xfer & ~out_xfer;
      end
      PS_FULL: load_main_skid = out_xfer;
      default: ;
    endcase
  end

  // NOTE: payload registers are reset too, so the skid entry is a known RST_DATA and X never escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q    <= RST_DATA;
      skid_q    <= RST_DATA;
      flushed_q <= 1'b1;
    end else if (flush) begin
      main_q    <= RST_DATA;
      skid_q    <= RST_DATA;
      flushed_q <= 1'b1;
    end else begin
      if (load_main_up)        main_q <= up_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= up_data;
      // The marker drops one cycle after a real item is first visible downstream.
      if (down_valid)          flushed_q <= 1'b0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc, bubble_inc;

  // A flush cycle is charged to flush_cnt only.
  assign stall_inc  = ~flush & down_valid & ~down_ready;
  assign bubble_inc = ~flush & ~down_valid;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bubble_inc),
    .cnt (bubble_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a FIFO-of-capacity-2 reference model checked every cycle.
// Counter expectations follow PIPE_STAGE_PERF_EN (all zero when undefined).
module tb_pipe_skid_stage;

  localparam int                DATA_W   = 16;
  localparam logic [DATA_W-1:0] RST_DATA = 16'hBEEF;
  localparam int                CNT_W    = 4;
  localparam int                CMAX     = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              up_valid = 1'b0;
  logic              up_ready;
  logic [DATA_W-1:0] up_data = '0;
  logic              down_valid;
  logic              down_ready = 1'b0;
  logic [DATA_W-1:0] down_data;
  logic              down_flushed;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W   (DATA_W),
    .RST_DATA (RST_DATA),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .up_valid     (up_valid),
    .up_ready     (up_ready),
    .up_data      (up_data),
    .down_valid   (down_valid),
    .down_ready   (down_ready),
    .down_data    (down_data),
    .down_flushed (down_flushed),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the stage behaves as an ordered store of at most two items.
  logic [DATA_W-1:0] sb_q[$];
  bit                m_flushed = 1'b1;
  int                m_stall = 0, m_bubble = 0, m_flush = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
    return PERF ? CNT_W'(v) : '0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Monitor: samples mid-cycle, compares against the model, then advances the model.
  always @(negedge clk) begin
    logic [DATA_W-1:0] exp_data;
    bit                occ_nonempty, model_ready;
    if (rst) begin
      check("rst_down_valid", 64'(down_valid), 64'd0);
      check("rst_down_data", 64'(down_data), 64'(RST_DATA));
      check("rst_down_flushed", 64'(down_flushed), 64'd1);
      check("rst_up_ready", 64'(up_ready), 64'd1);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
      check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
      sb_q.delete();
      m_flushed = 1'b1;
      m_stall   = 0;
      m_bubble  = 0;
      m_flush   = 0;
    end else begin
      occ_nonempty = (sb_q.size() > 0);
      model_ready  = (sb_q.size() < 2);
      exp_data     = occ_nonempty ? sb_q[0] : RST_DATA;
      check("down_valid", 64'(down_valid), 64'(occ_nonempty));
      check("up_ready", 64'(up_ready), 64'(model_ready));
      check("down_data", 64'(down_data), 64'(exp_data));
      check("down_flushed", 64'(down_flushed), 64'(m_flushed));
      check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt(m_stall)));
      check("bubble_cnt", 64'(bubble_cnt), 64'(exp_cnt(m_bubble)));
      check("flush_cnt", 64'(flush_cnt), 64'(exp_cnt(m_flush)));
      if (flush) begin
        sb_q.delete();
        m_flushed = 1'b1;
        m_flush   = sat_inc(m_flush);
      end else begin
        if (occ_nonempty && !down_ready) m_stall = sat_inc(m_stall);
        if (!occ_nonempty)               m_bubble = sat_inc(m_bubble);
        if (occ_nonempty)                m_flushed = 1'b0;
        if (occ_nonempty && down_ready)  void'(sb_q.pop_front());
        if (up_valid && model_ready)     sb_q.push_back(up_data);
      end
    end
  end

  // One cycle of stimulus; idle payload is random so a stray sample would be caught.
  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit dr, input bit fl);
    @(posedge clk);
    #1;
    up_valid   = v;
    up_data    = v ? d : DATA_W'($urandom);
    down_ready = dr;
    flush      = fl;
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) drive(1'b0, '0, dr, 1'b0);
  endtask

  // Offer items in order, holding each until up_ready accepts it.
  task automatic send(input logic [DATA_W-1:0] items[$], input bit dr);
    int idx = 0;
    int budget = 0;
    while (idx < items.size()) begin
      drive(1'b1, items[idx], dr, 1'b0);
      if (up_ready) idx++;
      budget++;
      if (budget > 64) begin
        check("send_timeout", 64'(idx), 64'(items.size()));
        break;
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] items[$];

    idle(3, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Streaming pass-through.
    items = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8};
    send(items, 1'b1);
    idle(3, 1'b1);

    // Back-pressure: A, B fill the stage, C waits upstream.
    drive(1'b1, 16'hA, 1'b0, 1'b0);
    drive(1'b1, 16'hB, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'hC, 1'b0, 1'b0);
    items = '{16'hC};
    send(items, 1'b1);
    idle(4, 1'b1);

    // Flush while full with a concurrent offer of 0xD.
    drive(1'b1, 16'h11, 1'b0, 1'b0);
    drive(1'b1, 16'h12, 1'b0, 1'b0);
    drive(1'b1, 16'hD, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Flushed marker after the first post-flush item.
    drive(1'b1, 16'hE, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // Long stall to saturate the stall counter.
    drive(1'b1, 16'h21, 1'b0, 1'b0);
    idle(20, 1'b0);
    idle(2, 1'b1);

    // Asynchronous reset while full.
    drive(1'b1, 16'h31, 1'b0, 1'b0);
    drive(1'b1, 16'h32, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    idle(2, 1'b1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), DATA_W'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
    end
    idle(4, 1'b1);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
